// File: rtl/beep_melody_seq_if.sv
// Score-ROM and tone-generator signal bundle for the melody sequencer.
// The slave side is the sequencer; the master side drives control and ROM data.
interface beep_melody_seq_if #(
  parameter int unsigned ADDR_W = 6
);
  logic              start;
  logic              stop;
  logic              loop_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic [17:0]       note_period;
  logic              tone_en;
  logic              note_start;
  logic              busy;
  logic              done;

  modport slave (
    input  start, stop, loop_en, rom_data,
    output rom_addr, note_period, tone_en, note_start, busy, done
  );

  modport master (
    output start, stop, loop_en, rom_data,
    input  rom_addr, note_period, tone_en, note_start, busy, done
  );
endinterface

// File: rtl/beep_melody_seq.sv
// Melody sequencer: walks a score ROM and drives note period / tone enable
// for the downstream beep tone generator, timing each note in beats.
module beep_melody_seq #(
  parameter logic [24:0] BEAT_CNT_MAX = 25'd24_999_999,
  parameter logic [24:0] GAP_CYCLES   = 25'd2_500_000,
  parameter int unsigned ADDR_W       = 6,
  parameter logic [17:0] DO           = 18'd190839,
  parameter logic [17:0] RE           = 18'd170067,
  parameter logic [17:0] MI           = 18'd151415,
  parameter logic [17:0] FA           = 18'd143265,
  parameter logic [17:0] SO           = 18'd127550,
  parameter logic [17:0] LA           = 18'd113635,
  parameter logic [17:0] XI           = 18'd101214
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  beep_melody_seq_if.slave   bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_PLAY   = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  // Beat-counter value on the last sounding cycle of a note's final beat;
  // the remaining cycles of that beat form the articulation gap.
  localparam logic [24:0] PLAY_LAST = BEAT_CNT_MAX - GAP_CYCLES;

  logic [2:0]        state,       state_n;
  logic [ADDR_W-1:0] rom_addr,    rom_addr_n;
  logic [17:0]       note_period, note_period_n;
  logic              tone_en,     tone_en_n;
  logic              note_start,  note_start_n;
  logic              busy,        busy_n;
  logic              done,        done_n;
  logic [24:0]       beat_cnt,    beat_cnt_n;
  logic [3:0]        beats_left,  beats_left_n;

  logic       rom_end;
  logic [2:0] rom_code;
  logic [3:0] rom_dur;

  assign rom_end  = bus.rom_data[7];
  assign rom_code = bus.rom_data[6:4];
  assign rom_dur  = bus.rom_data[3:0];

  function automatic logic [17:0] code_period(input logic [2:0] code);
    case (code)
      3'd1:    code_period = DO;
      3'd2:    code_period = RE;
      3'd3:    code_period = MI;
      3'd4:    code_period = FA;
      3'd5:    code_period = SO;
      3'd6:    code_period = LA;
      3'd7:    code_period = XI;
      default: code_period = '0;
    endcase
  endfunction

  always_comb begin
    state_n       = state;
    rom_addr_n    = rom_addr;
    note_period_n = note_period;
    tone_en_n     = tone_en;
    note_start_n  = 1'b0;
    busy_n        = busy;
    done_n        = 1'b0;
    beat_cnt_n    = beat_cnt;
    beats_left_n  = beats_left;

    case (state)
      S_IDLE: begin
        if (bus.start && !bus.stop) begin
          state_n    = S_FETCH;
          rom_addr_n = '0;
          busy_n     = 1'b1;
        end
      end

      S_FETCH: state_n = S_DECODE;

      S_DECODE: begin
        if (!rom_end) begin
          state_n       = S_PLAY;
          note_period_n = code_period(rom_code);
          tone_en_n     = (rom_code != 3'd0);
          note_start_n  = 1'b1;
          beats_left_n  = (rom_dur == 4'd0) ? 4'd1 : rom_dur;
          beat_cnt_n    = '0;
        end else if (bus.loop_en && (rom_addr != '0)) begin
          state_n    = S_FETCH;
          rom_addr_n = '0;
        end else begin
          state_n = S_DONE;
          done_n  = 1'b1;
        end
      end

      S_PLAY: begin
        if (beat_cnt == BEAT_CNT_MAX) begin
          beat_cnt_n   = '0;
          beats_left_n = beats_left - 4'd1;
        end else begin
          beat_cnt_n = beat_cnt + 25'd1;
        end
        if ((beats_left == 4'd1) && (beat_cnt == PLAY_LAST)) begin
          tone_en_n = 1'b0;
          if (GAP_CYCLES == '0) begin
            state_n    = S_FETCH;
            rom_addr_n = rom_addr + ADDR_W'(1);
          end else begin
            state_n = S_GAP;
          end
        end
      end

      // Gap keeps counting the final beat, so note length stays beat-aligned.
      S_GAP: begin
        if (beat_cnt == BEAT_CNT_MAX) begin
          state_n      = S_FETCH;
          beat_cnt_n   = '0;
          beats_left_n = '0;
          rom_addr_n   = rom_addr + ADDR_W'(1);
        end else begin
          beat_cnt_n = beat_cnt + 25'd1;
        end
      end

      S_DONE: begin
        state_n       = S_IDLE;
        busy_n        = 1'b0;
        rom_addr_n    = '0;
        note_period_n = '0;
      end

      default: begin
        state_n       = S_IDLE;
        busy_n        = 1'b0;
        rom_addr_n    = '0;
        note_period_n = '0;
        tone_en_n     = 1'b0;
        beat_cnt_n    = '0;
        beats_left_n  = '0;
      end
    endcase

    if (bus.stop && (state != S_IDLE)) begin
      state_n       = S_IDLE;
      rom_addr_n    = '0;
      note_period_n = '0;
      tone_en_n     = 1'b0;
      note_start_n  = 1'b0;
      busy_n        = 1'b0;
      done_n        = 1'b0;
      beat_cnt_n    = '0;
      beats_left_n  = '0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= S_IDLE;
      rom_addr    <= '0;
      note_period <= '0;
      tone_en     <= 1'b0;
      note_start  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      beat_cnt    <= '0;
      beats_left  <= '0;
    end else begin
      state       <= state_n;
      rom_addr    <= rom_addr_n;
      note_period <= note_period_n;
      tone_en     <= tone_en_n;
      note_start  <= note_start_n;
      busy        <= busy_n;
      done        <= done_n;
      beat_cnt    <= beat_cnt_n;
      beats_left  <= beats_left_n;
    end
  end

  assign bus.rom_addr    = rom_addr;
  assign bus.note_period = note_period;
  assign bus.tone_en     = tone_en;
  assign bus.note_start  = note_start;
  assign bus.busy        = busy;
  assign bus.done        = done;

endmodule
